// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounced readback of a multiplexed seven-segment bus into BCD digits
module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stb,
  input  logic [6:0]        i_seg_in,
  input  logic [NDIG-1:0]   i_dig_sel,
  input  logic              i_err_clr,
  output logic [4*NDIG-1:0] o_dout,
  output logic [NDIG-1:0]   o_vld,
  output logic [NDIG-1:0]   o_err,
  output logic              o_upd,
  output logic              o_sel_err
);
  localparam logic [3:0] LIM = 4'(STABLE);
  logic [6:0]      r_seg;
  logic [NDIG-1:0] r_sel;
  logic            r_sv;
  logic            r_bad;
  logic [6:0]      r_pat [NDIG];
  logic [3:0]      r_cnt [NDIG];
  logic            w_onehot;
  logic            w_legal;
  logic [3:0]      w_val;
  logic [3:0]      w_ncnt [NDIG];
  logic [NDIG-1:0] w_hit;
  logic [NDIG-1:0] w_settle;
  logic [NDIG-1:0] w_chg;

  assign w_onehot = $onehot(i_dig_sel);

  always_comb begin
    w_legal = 1'b1;
    w_val   = 4'd0;
    case (r_seg)
      7'b0111111:             w_val = 4'd0;
      7'b0000110:             w_val = 4'd1;
      7'b1011011:             w_val = 4'd2;
      7'b1001111:             w_val = 4'd3;
      7'b1100110:             w_val = 4'd4;
      7'b1101101:             w_val = 4'd5;
      7'b1111101:             w_val = 4'd6;
      7'b0000111, 7'b0100111: w_val = 4'd7;
      7'b1111111:             w_val = 4'd8;
      7'b1101111:             w_val = 4'd9;
      default:                w_legal = 1'b0;
    endcase
  end

  // a saturated run only re-settles when every sample is meant to settle
  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      w_hit[i]    = r_sv & r_sel[i];
      w_ncnt[i]   = (r_seg != r_pat[i]) ? 4'd1 : (r_cnt[i] >= LIM ? LIM : r_cnt[i] + 4'd1);
      w_settle[i] = w_hit[i] && w_ncnt[i] == LIM && (r_seg != r_pat[i] || r_cnt[i] != LIM || STABLE == 1);
      w_chg[i]    = w_settle[i] && w_legal && (!o_vld[i] || o_dout[4*i +: 4] != w_val);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg     <= '0;
      r_sel     <= '0;
      r_sv      <= 1'b0;
      r_bad     <= 1'b0;
      o_dout    <= '0;
      o_vld     <= '0;
      o_err     <= '0;
      o_upd     <= 1'b0;
      o_sel_err <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        r_pat[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_sv      <= i_stb & w_onehot;
      r_bad     <= i_stb & ~w_onehot;
      if (i_stb) begin
        r_seg <= i_seg_in;
        r_sel <= i_dig_sel;
      end
      o_sel_err <= r_bad;
      o_upd     <= |w_chg;
      o_err     <= (o_err & ~{NDIG{i_err_clr}}) | (w_settle & ~{NDIG{w_legal}});
      for (int i = 0; i < NDIG; i++) begin
        if (w_hit[i]) begin
          r_pat[i] <= r_seg;
          r_cnt[i] <= w_ncnt[i];
        end
        if (w_settle[i]) begin
          o_vld[i] <= w_legal;
          if (w_legal)
            o_dout[4*i +: 4] <= w_val;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench for STABLE=3 and STABLE=1 builds driven in lockstep
module tb_seg7_scan_decoder;
  localparam int ST0 = 3;
  localparam int ST1 = 1;

  typedef struct packed {
    logic [15:0] d0, d1;
    logic [3:0]  v0, v1, e0, e1;
    logic        u0, u1, s0, s1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        clr = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  sel = '0;
  logic [15:0] dout0, dout1;
  logic [3:0]  vld0, vld1, err0, err1;
  logic        upd0, upd1, se0, se1;

  int n_run = 0;
  int n_fail = 0;

  logic [6:0] segs [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [6:0] m_pat  [2][4];
  int         m_cnt  [2][4];
  logic [3:0] m_dout [2][4];
  logic [3:0] m_vld  [2];
  logic [3:0] m_err  [2];
  logic       m_upd  [2];
  logic       m_se   [2];
  logic       p_v, p_bad;
  logic [6:0] p_seg;
  logic [3:0] p_sel;
  exp_t       q [$];

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NDIG(4), .STABLE(ST0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_stb(stb), .i_seg_in(seg), .i_dig_sel(sel), .i_err_clr(clr),
    .o_dout(dout0), .o_vld(vld0), .o_err(err0), .o_upd(upd0), .o_sel_err(se0));

  seg7_scan_decoder #(.NDIG(4), .STABLE(ST1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_stb(stb), .i_seg_in(seg), .i_dig_sel(sel), .i_err_clr(clr),
    .o_dout(dout1), .o_vld(vld1), .o_err(err1), .o_upd(upd1), .o_sel_err(se1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void dec(input logic [6:0] s, output bit ok, output logic [3:0] v);
    ok = 1'b0;
    v  = 4'd0;
    for (int k = 0; k < 10; k++)
      if (s == segs[k]) begin
        ok = 1'b1;
        v  = 4'(k);
      end
    if (s == 7'h27) begin
      ok = 1'b1;
      v  = 4'd7;
    end
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 4; d++) begin
        m_pat[m][d]  = '0;
        m_cnt[m][d]  = 0;
        m_dout[m][d] = '0;
      end
      m_vld[m] = '0;
      m_err[m] = '0;
      m_upd[m] = 1'b0;
      m_se[m]  = 1'b0;
    end
    p_v   = 1'b0;
    p_bad = 1'b0;
    p_seg = '0;
    p_sel = '0;
  endtask

  // one rising edge: previous strobe is resolved per digit, then the current strobe is captured
  task automatic model_edge();
    int s, d;
    bit sat, ok;
    logic [3:0] v, ne;
    for (int m = 0; m < 2; m++) begin
      s = (m == 0) ? ST0 : ST1;
      m_upd[m] = 1'b0;
      m_se[m]  = p_bad;
      ne = clr ? 4'b0 : m_err[m];
      if (p_v) begin
        d = 0;
        for (int k = 0; k < 4; k++) if (p_sel[k]) d = k;
        sat = 1'b0;
        if (p_seg == m_pat[m][d]) begin
          sat = (m_cnt[m][d] == s);
          m_cnt[m][d] = sat ? s : m_cnt[m][d] + 1;
        end else begin
          m_pat[m][d] = p_seg;
          m_cnt[m][d] = 1;
        end
        if (m_cnt[m][d] == s && (!sat || s == 1)) begin
          dec(p_seg, ok, v);
          if (ok) begin
            m_upd[m]     = !m_vld[m][d] || m_dout[m][d] != v;
            m_dout[m][d] = v;
            m_vld[m][d]  = 1'b1;
          end else begin
            m_vld[m][d] = 1'b0;
            ne[d] = 1'b1;
          end
        end
      end
      m_err[m] = ne;
    end
    p_v   = stb && $countones(sel) == 1;
    p_bad = stb && $countones(sel) != 1;
    if (stb) begin
      p_seg = seg;
      p_sel = sel;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.d0 = {m_dout[0][3], m_dout[0][2], m_dout[0][1], m_dout[0][0]};
    e.d1 = {m_dout[1][3], m_dout[1][2], m_dout[1][1], m_dout[1][0]};
    e.v0 = m_vld[0];
    e.v1 = m_vld[1];
    e.e0 = m_err[0];
    e.e1 = m_err[1];
    e.u0 = m_upd[0];
    e.u1 = m_upd[1];
    e.s0 = m_se[0];
    e.s1 = m_se[1];
    return e;
  endfunction

  task automatic step(input bit b, input logic [6:0] s, input logic [3:0] d, input bit c);
    exp_t e;
    stb = b;
    seg = s;
    sel = d;
    clr = c;
    model_edge();
    q.push_back(snap());
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("dout_s3", 32'(dout0), 32'(e.d0));
    chk("dout_s1", 32'(dout1), 32'(e.d1));
    chk("vld_s3", 32'(vld0), 32'(e.v0));
    chk("vld_s1", 32'(vld1), 32'(e.v1));
    chk("err_s3", 32'(err0), 32'(e.e0));
    chk("err_s1", 32'(err1), 32'(e.e1));
    chk("upd_s3", 32'(upd0), 32'(e.u0));
    chk("upd_s1", 32'(upd1), 32'(e.u1));
    chk("selerr_s3", 32'(se0), 32'(e.s0));
    chk("selerr_s1", 32'(se1), 32'(e.s1));
    @(negedge clk);
  endtask

  task automatic samples(input int n, input logic [6:0] s, input logic [3:0] d);
    for (int k = 0; k < n; k++) step(1'b1, s, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 7'h00, 4'h0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'({dout1, dout0}), 32'h0);
    chk({tag, "_vld"}, 32'({vld1, vld0}), 32'h0);
    chk({tag, "_err"}, 32'({err1, err0}), 32'h0);
    chk({tag, "_pulse"}, 32'({upd1, upd0, se1, se0}), 32'h0);
  endtask

  initial begin
    logic [6:0] rs;
    logic [3:0] rd;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) step(1'b1, segs[d + 1], 4'(1 << d), 1'b0);
    idle(2);
    samples(3, segs[5], 4'b0001);
    idle(1);
    samples(1, segs[8], 4'b0001);
    samples(3, segs[5], 4'b0001);
    idle(1);
    samples(3, segs[9], 4'b0001);
    idle(2);
    samples(3, 7'h00, 4'b0100);
    step(1'b0, 7'h00, 4'h0, 1'b1);
    idle(1);
    step(1'b0, 7'h00, 4'h0, 1'b1);
    idle(1);
    step(1'b1, segs[8], 4'b0000, 1'b0);
    step(1'b1, segs[8], 4'b0110, 1'b0);
    idle(2);
    samples(3, 7'h27, 4'b1000);
    idle(1);
    samples(3, 7'h07, 4'b1000);
    idle(2);
    samples(2, segs[6], 4'b0010);
    stb = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    samples(1, segs[6], 4'b0010);
    samples(3, segs[6], 4'b0010);
    idle(2);
    for (int k = 0; k < 40; k++) begin
      rs = segs[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) rs = 7'h27;
      if ($urandom_range(0, 9) == 0) rs = 7'(($urandom_range(0, 127)));
      rd = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rd = 4'($urandom_range(0, 15));
      for (int j = 0; j < int'($urandom_range(1, 4)); j++)
        step(1'b1, rs, rd, $urandom_range(0, 7) == 0);
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers BCD digits from a multiplexed, active-high seven-segment drive bus (SEG_IN + one-hot digit select). It is the readback counterpart of the BCD-to-segment encoder: it sits on the display drive lines in the BER test design and lets the bench or on-chip self-check confirm what is actually being displayed. Each digit is debounced by requiring STABLE consecutive identical samples before its output updates. Patterns outside the digit table are flagged per digit.

## Interface
- NDIG, 4: number of multiplexed digits, 1..8.
- STABLE, 3: consecutive identical samples required before a digit updates, 1..15.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- STB  in  1  sample strobe; SEG_IN and DIG_SEL are valid when high.
- SEG_IN  in  7  segment levels, bit0=a … bit6=g, 1 = lit.
- DIG_SEL  in  NDIG  one-hot digit select; bit i = digit i.
- ERR_CLR  in  1  clears ERR (level, synchronous).
- DOUT  out  4*NDIG  decoded BCD; digit i in DOUT[4i+3:4i].
- VLD  out  NDIG  digit i holds a stable, legal value.
- ERR  out  NDIG  sticky: digit i settled on an illegal pattern.
- UPD  out  1  one-cycle pulse: some DOUT digit changed value.
- SEL_ERR  out  1  one-cycle pulse: strobed DIG_SEL was not one-hot.

## Operation
- Legal patterns (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111 or 0100111, 8=1111111, 9=1101111. All other codes, including 0000000, are illegal.
- Stage 1: on an edge with STB=1, register SEG_IN, DIG_SEL, and a sample-valid bit. The bit is set only if DIG_SEL is exactly one-hot.
- Stage 1: if STB=1 and DIG_SEL is not one-hot (zero or multiple bits), discard the sample and assert SEL_ERR on the next cycle. No digit state changes.
- Stage 2, per selected digit i, holding a last-pattern register PAT[i] (7b) and counter CNT[i] (4b):
  - SEG_IN==PAT[i]: CNT[i] <= min(CNT[i]+1, STABLE).
  - Otherwise: PAT[i] <= SEG_IN; CNT[i] <= 1.
- Settle: when the new CNT[i] value equals STABLE (reached, not already saturated):
  - Legal pattern: DOUT digit i <= its value; VLD[i] <= 1. UPD pulses if the new value differs from the old DOUT digit, or VLD[i] was 0.
  - Illegal pattern: VLD[i] <= 0; ERR[i] <= 1; DOUT digit i holds its previous value; no UPD.
- A changing pattern never produces an intermediate DOUT value. The digit keeps its previous output until the new pattern settles.
- When STABLE=1, every accepted sample settles immediately.
- ERR_CLR=1 clears all ERR bits. If a set and a clear hit the same bit in the same cycle, the set wins.
- Unselected digits are untouched. Samples with STB=0 are ignored entirely.

## Timing
- Reset values: DOUT=0, VLD=0, ERR=0, UPD=0, SEL_ERR=0, all PAT=0, all CNT=0.
- Latency: the sample strobed at edge k that brings CNT to STABLE updates DOUT, VLD and ERR at edge k+1. UPD is high for the single cycle after edge k+1.
- SEL_ERR is high for the single cycle after edge k+1 for a non-one-hot sample strobed at edge k.
- STB may be high every cycle. Back-to-back samples to the same or different digits are fully pipelined with no stalls.
- Reset mid-operation clears all counters. Partial stability runs are lost; after reset, STABLE fresh samples are needed.
- Throughput: one sample per cycle. Stage 2 forwards PAT/CNT when consecutive samples hit the same digit.

## Test plan
- Reset then scan: NDIG=4, STABLE=3. Drive digits 0..3 with 1,2,3,4 for 3 rounds of STB on consecutive cycles. -> DOUT=16'h4321, VLD=4'hF, 4 UPD pulses, each 1 cycle after the 3rd sample of its digit.
- Glitch rejection: digit 0 stable at 5. Inject one sample of 8, then resume 5. -> DOUT digit 0 stays 5, no UPD. After 3 samples of 9 -> digit becomes 9, with one UPD.
- Illegal pattern: 3 samples of 0000000 on digit 2. -> ERR=4'b0100, VLD[2]=0, DOUT digit 2 unchanged. ERR_CLR in the same cycle as the set -> ERR stays set. ERR_CLR later -> ERR=0.
- Select errors: STB with DIG_SEL=4'b0000, then 4'b0110. -> two SEL_ERR pulses, no CNT/PAT change, DOUT unchanged.
- Both 7 variants: 3 samples of 0100111 give 7. Then 3 samples of 0000111 give 7 again, with no UPD (value unchanged).
- Async reset: assert RST mid-run between clock edges. -> all outputs 0 immediately. After release, digit values need 3 fresh samples; STABLE=1 build updates on every sample.
